divider_control: RTL and testbench

//  Sequencer for the bitslice restoring-divider datapath; sits directly upstream of the slice array.

---
 rtl/divider_control_if.sv | 25 ++
 rtl/divider_control.sv | 104 ++++++++++
 tb/tb_divider_control.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/divider_control_if.sv
// Handshake and slice-array control bundle for the restoring-divider sequencer.
interface divider_control_if;
    logic Start;
    logic Test;
    logic nBorrow;
    logic nZero;
    logic Ready;
    logic Load;
    logic LoadAcc;
    logic LoadResult;
    logic QuotientBit;
    logic ShiftZero;
    logic Done;
    logic Error;

    modport master (
        output Start, Test, nBorrow, nZero,
        input  Ready, Load, LoadAcc, LoadResult, QuotientBit, ShiftZero, Done, Error
    );

    modport slave (
        input  Start, Test, nBorrow, nZero,
        output Ready, Load, LoadAcc, LoadResult, QuotientBit, ShiftZero, Done, Error
    );
endinterface

// File: rtl/divider_control.sv
// Sequencer for the bitslice restoring divider: IDLE -> LOAD -> ITER (WIDTH cycles) -> DONE.
// Optional divide-by-zero early exit when DIVZERO_DETECT_EN is defined.
module divider_control #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    divider_control_if.slave   bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;

`ifdef DIVZERO_DETECT_EN
    logic error;
    logic errorNext;

    // Divide-by-zero flag lives until the next accepted Start.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            error <= 1'b0;
        end else begin
            error <= errorNext;
        end
    end
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    // Scan mode freezes the sequencer by leaving every next value at its current one.
    always_comb begin
        stateNext = state;
        countNext = count;
`ifdef DIVZERO_DETECT_EN
        errorNext = error;
`endif
        if (!bus.Test) begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        stateNext = LOAD;
`ifdef DIVZERO_DETECT_EN
                        errorNext = 1'b0;
`endif
                    end
                end
                LOAD: begin
                    countNext = CNT_W'(WIDTH - 1);
                    stateNext = ITER;
`ifdef DIVZERO_DETECT_EN
                    // Divisor is on the slice operand inputs during LOAD, so nZero is valid here.
                    if (!bus.nZero) begin
                        stateNext = DONE;
                        errorNext = 1'b1;
                    end
`endif
                end
                ITER: begin
                    if (count == '0) begin
                        stateNext = DONE;
                    end else begin
                        countNext = count - CNT_W'(1);
                    end
                end
                DONE: begin
                    stateNext = IDLE;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    assign bus.Ready       = (state == IDLE);
    assign bus.Load        = (state == LOAD) && !bus.Test;
    assign bus.LoadResult  = (state == ITER) && !bus.Test;
    assign bus.Done        = (state == DONE) && !bus.Test;
    // A non-borrowing trial subtract both commits the difference and yields a 1 quotient bit.
    assign bus.LoadAcc     = (state == ITER) && !bus.Test && bus.nBorrow;
    assign bus.QuotientBit = (state == ITER) && bus.nBorrow;
    assign bus.ShiftZero   = 1'b0;

`ifdef DIVZERO_DETECT_EN
    assign bus.Error = error;
`else
    logic unusedNZero;
    assign unusedNZero = bus.nZero;
    assign bus.Error   = 1'b0;
`endif
endmodule

// File: tb/tb_divider_control.sv
// Scoreboard bench: divider_control closed around a behavioural 8-bit restoring slice array.
module tb_divider_control;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    divider_control_if bus ();

    divider_control #(.WIDTH(8)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       err;
        logic       chkQR;
        int         doneCyc;
        int         lr;
    } exp_t;

    exp_t sb[$];

    // Behavioural slice array: {acc,dq} shifts left, trial subtract of the divisor.
    logic [7:0] dividendIn = 8'd0;
    logic [7:0] divisorIn  = 8'd1;
    logic [7:0] acc = 8'd0;
    logic [7:0] dq  = 8'd0;
    logic [7:0] res = 8'd0;
    logic [7:0] dvr = 8'd1;
    logic [8:0] trial;

    assign trial       = {acc, dq[7]};
    assign bus.nBorrow = (trial >= {1'b0, dvr});
    assign bus.nZero   = (divisorIn != 8'd0);

    always @(posedge clk) begin
        if (bus.Load) begin
            acc <= 8'd0;
            dq  <= dividendIn;
            res <= 8'd0;
            dvr <= divisorIn;
        end else if (bus.LoadResult) begin
            res <= {res[6:0], bus.QuotientBit};
            dq  <= {dq[6:0], 1'b0};
            acc <= bus.LoadAcc ? 8'(trial - {1'b0, dvr}) : trial[7:0];
        end
    end

    task automatic check(input string name, input int act, input int req);
        assertions++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    int loadCnt = 0;
    int lrCnt   = 0;

    // Monitor: pops an expectation on every Done pulse.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            loadCnt = 0;
            lrCnt   = 0;
        end else begin
            if (bus.Load)       loadCnt++;
            if (bus.LoadResult) lrCnt++;
            if (bus.Done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", cyc, -1);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.doneCyc);
                    check("error_at_done", int'(bus.Error), int'(e.err));
                    check("load_pulses", loadCnt, 1);
                    check("loadresult_cycles", lrCnt, e.lr);
                    if (e.chkQR) begin
                        check("quotient", int'(res), int'(e.q));
                        check("remainder", int'(acc), int'(e.r));
                    end
                end
                loadCnt = 0;
                lrCnt   = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle Start; returns in the LOAD cycle.
    task automatic issue(input logic [7:0] dd, input logic [7:0] dv, input logic [7:0] q,
                         input logic [7:0] r, input logic err, input int lat, input bit expect_done);
        exp_t e;
        step();
        dividendIn = dd;
        divisorIn  = dv;
        bus.Start  = 1'b1;
        e.q = q; e.r = r; e.err = err; e.chkQR = !err;
        e.doneCyc = cyc + lat;
        e.lr = err ? 0 : 8;
        if (expect_done) sb.push_back(e);
        step();
        bus.Start = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (bus.Done) break;
        end
        if (!bus.Done) begin
            check("done_timeout", int'(bus.Done), 1);
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s;
        rst       = 1'b1;
        bus.Start = 1'b0;
        bus.Test  = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", int'(bus.Ready), 1);
        check("reset_strobes", int'({bus.Load, bus.LoadAcc, bus.LoadResult, bus.QuotientBit, bus.Done, bus.Error}), 0);
        check("shift_zero", int'(bus.ShiftZero), 0);

        // 1: 100/7, plus a stray Start mid-ITER that must be ignored
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 10, 1'b1);
        step(); step(); step();
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        waitDone();

        // 2: back-to-back, Start in the cycle after Done
        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 10, 1'b1);
        waitDone();
        issue(8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 10, 1'b1);
        waitDone();

        // 3: reset in the 4th ITER cycle abandons the division
        issue(8'd100, 8'd7, 8'd0, 8'd0, 1'b0, 10, 1'b0);
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", int'(bus.Ready), 1);
        check("abort_strobes", int'({bus.Load, bus.LoadAcc, bus.LoadResult, bus.QuotientBit, bus.Done}), 0);
        repeat (12) step();
        issue(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 10, 1'b1);
        waitDone();

        // 4: zero divisor
`ifdef DIVZERO_DETECT_EN
        issue(8'd50, 8'd0, 8'd0, 8'd0, 1'b1, 2, 1'b1);
`else
        issue(8'd50, 8'd0, 8'd255, 8'd50, 1'b0, 10, 1'b1);
`endif
        waitDone();
        step(); step(); step();
        @(negedge clk);
`ifdef DIVZERO_DETECT_EN
        check("error_hold", int'(bus.Error), 1);
`else
        check("error_hold", int'(bus.Error), 0);
`endif
        issue(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 10, 1'b1);
        @(negedge clk);
        check("error_cleared", int'(bus.Error), 0);
        check("load_in_load_state", int'(bus.Load), 1);
        waitDone();

        // 5: scan freeze for 5 cycles mid-ITER
        issue(8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 15, 1'b1);
        step(); step(); step();
        bus.Test = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("test_strobes", int'({bus.Load, bus.LoadAcc, bus.LoadResult, bus.Done}), 0);
            check("test_not_idle", int'(bus.Ready), 0);
            step();
        end
        bus.Test = 1'b0;
        waitDone();

        // 6: Start held high: one division per IDLE visit
        step();
        dividendIn = 8'd77;
        divisorIn  = 8'd4;
        bus.Start  = 1'b1;
        s = cyc;
        sb.push_back('{q: 8'd19, r: 8'd1, err: 1'b0, chkQR: 1'b1, doneCyc: s + 10, lr: 8});
        sb.push_back('{q: 8'd19, r: 8'd1, err: 1'b0, chkQR: 1'b1, doneCyc: s + 21, lr: 8});
        repeat (12) step();
        bus.Start = 1'b0;
        waitDone();
        repeat (15) step();
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
